// File: rtl/rv_alu_pkg.sv
// Shared ALU operation codes and RV32I field constants for the decoder and the encoder.
// encode_alu() builds the R/I-type word and flags requests that have no legal encoding.
package rv_alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef struct packed {
        logic        illegal;
        logic [31:0] instr;
    } enc_result_t;

    function automatic enc_result_t encode_alu(
        input alu_ctrl_e   ctrl,
        input logic        is_imm,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm
    );
        enc_result_t res;
        logic [2:0]  f3;
        logic        is_shift;
        f3 = F3_ADD_SUB;
        case (ctrl)
            ALU_ADD, ALU_SUB: f3 = F3_ADD_SUB;
            ALU_AND:          f3 = F3_AND;
            ALU_OR:           f3 = F3_OR;
            ALU_XOR:          f3 = F3_XOR;
            ALU_SLL:          f3 = F3_SLL;
            ALU_SRL:          f3 = F3_SRL;
            ALU_SLT:          f3 = F3_SLT;
            default:          f3 = F3_ADD_SUB;
        endcase
        is_shift = (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
        // No subi exists, and an I-type shift only has a 5-bit shamt.
        res.illegal = is_imm && ((ctrl == ALU_SUB) || (is_shift && (imm[11:5] != 7'd0)));
        if (is_imm) begin
            res.instr = {imm, rs1, f3, rd, OP_ITYPE};
        end else begin
            res.instr = {(ctrl == ALU_SUB) ? F7_SUB : F7_BASE, rs2, rs1, f3, rd, OP_RTYPE};
        end
        return res;
    endfunction

endpackage

// File: rtl/enc_out_fifo.sv
// Two-entry valid/ready FIFO holding {instruction, address} words for the imem port.
// The head entry resets to RST_VAL so the output bus shows a defined value after reset.
module enc_out_fifo #(
    parameter int unsigned       W       = 42,
    parameter logic [W-1:0]      RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count_q;
    logic         pop;

    assign pop_valid = (count_q != 2'd0);
    assign pop       = pop_valid && pop_ready;
    assign pop_data  = mem[rd_ptr];
    assign count     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]  <= RST_VAL;
            mem[1]  <= RST_VAL;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (clear) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_instr_encoder.sv
// Turns ALU-operation requests into RV32I R/I-type words tagged with sequential byte addresses.
// Illegal requests are consumed and counted but never reach the output queue.
module alu_instr_encoder
    import rv_alu_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_aluctrl,
    input  logic              in_is_imm,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  emit_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam int unsigned       FW   = 32 + ADDR_W;

    enc_result_t       enc;
    logic [1:0]        fifo_count;
    logic              accept;
    logic              push;
    logic [ADDR_W-1:0] addr_q;
    logic [FW-1:0]     head;

    // Ready is forced low during reset so nothing is taken while the queue is being flushed.
    assign in_ready = rst_n && (fifo_count != 2'd2) && !clear;
    assign accept   = in_valid && in_ready;
    assign enc      = encode_alu(alu_ctrl_e'(in_aluctrl), in_is_imm, in_rd, in_rs1, in_rs2, in_imm);
    assign push     = accept && !enc.illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= BASE;
            emit_count  <= '0;
            err_count   <= '0;
            err_illegal <= 1'b0;
        end else if (clear) begin
            addr_q      <= BASE;
            emit_count  <= '0;
            err_count   <= '0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= accept && enc.illegal;
            if (push) begin
                addr_q <= addr_q + ADDR_W'(4);
                if (emit_count != '1) emit_count <= emit_count + CNT_W'(1);
            end
            if (accept && enc.illegal && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

    enc_out_fifo #(
        .W       (FW),
        .RST_VAL ({32'd0, BASE})
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (push),
        .push_data ({enc.instr, addr_q}),
        .pop_valid (out_valid),
        .pop_ready (out_ready),
        .pop_data  (head),
        .count     (fifo_count)
    );

    assign out_instr = head[FW-1:ADDR_W];
    assign out_addr  = head[ADDR_W-1:0];

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Scoreboard bench for alu_instr_encoder: directed cases plus randomized requests,
// expected words and counts come from a field-level model of the RV32I encoding rules.
module tb_alu_instr_encoder;

    localparam int unsigned AW = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_aluctrl = '0;
    logic          in_is_imm = 1'b0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [11:0]   in_imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          err_illegal;
    logic [CW-1:0] err_count;
    logic [CW-1:0] emit_count;

    alu_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_aluctrl(in_aluctrl),
        .in_is_imm(in_is_imm), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .err_illegal(err_illegal), .err_count(err_count), .emit_count(emit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   instr;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   m_addr = 0;
    int   m_emit = 0;
    int   m_err = 0;
    bit   m_err_pend = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // funct3 per op code: add sub and or xor sll srl slt
    function automatic int ref_f3(input int op);
        int tbl[8] = '{0, 0, 7, 6, 4, 1, 5, 2};
        return tbl[op];
    endfunction

    function automatic bit ref_illegal(input int op, input bit is_imm, input int imm);
        if (!is_imm) return 1'b0;
        if (op == 1) return 1'b1;
        return ((op == 5) || (op == 6)) && (imm >= 32);
    endfunction

    function automatic logic [31:0] ref_instr(input int op, input bit is_imm, input int rd,
                                              input int rs1, input int rs2, input int imm);
        int unsigned w;
        if (is_imm)
            w = imm * (1 << 20) + rs1 * (1 << 15) + ref_f3(op) * (1 << 12) + rd * (1 << 7) + 19;
        else
            w = ((op == 1) ? 32 : 0) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
                + ref_f3(op) * (1 << 12) + rd * (1 << 7) + 51;
        return w;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_addr = 0;
        m_emit = 0;
        m_err = 0;
        m_err_pend = 1'b0;
    endfunction

    function automatic void model_accept();
        exp_t e;
        if (ref_illegal(int'(in_aluctrl), in_is_imm, int'(in_imm))) begin
            if (m_err < (1 << CW) - 1) m_err++;
            m_err_pend = 1'b1;
        end else begin
            e.instr = ref_instr(int'(in_aluctrl), in_is_imm, int'(in_rd), int'(in_rs1),
                                int'(in_rs2), int'(in_imm));
            e.addr  = AW'(m_addr);
            exp_q.push_back(e);
            m_addr = (m_addr + 4) % (1 << AW);
            if (m_emit < (1 << CW) - 1) m_emit++;
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input int op, input bit is_imm, input int rd, input int rs1,
                        input int rs2, input int imm, input bit rnd);
        int guard = 0;
        in_valid   = 1'b1;
        in_aluctrl = 3'(op);
        in_is_imm  = is_imm;
        in_rd      = 5'(rd);
        in_rs1     = 5'(rs1);
        in_rs2     = 5'(rs2);
        in_imm     = 12'(imm);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 100) begin
                chk("accept_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (rnd) out_ready = (guard > 3) ? 1'b1 : ($urandom_range(0, 1) == 1);
        end
        @(posedge clk);
        model_accept();
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
                chk("out_addr", 64'(out_addr), 64'(exp_q[0].addr));
                if (out_ready && !clear) void'(exp_q.pop_front());
            end
            chk("emit_count", 64'(emit_count), 64'(m_emit));
            chk("err_count", 64'(err_count), 64'(m_err));
            if (err_illegal || m_err_pend) chk("err_illegal", 64'(err_illegal), 64'(m_err_pend));
            m_err_pend = 1'b0;
        end
    end

    initial begin
        int op, imm;
        bit is_imm;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_counts", 64'({emit_count, err_count, err_illegal}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        send(0, 0, 3, 1, 2, 0, 0);
        chk("add_word", 64'(out_instr), 64'h002081B3);
        chk("add_addr", 64'(out_addr), 64'd0);
        send(1, 0, 5, 6, 7, 0, 0);
        chk("sub_word", 64'(out_instr), 64'h407302B3);
        chk("sub_addr", 64'(out_addr), 64'd4);
        send(0, 1, 1, 0, 0, 'hFFF, 0);
        chk("addi_word", 64'(out_instr), 64'hFFF00093);
        send(5, 1, 2, 2, 0, 'h003, 0);
        chk("slli_word", 64'(out_instr), 64'h00311113);
        send(6, 1, 2, 2, 0, 'h020, 0);
        chk("srli_bad_valid", 64'(out_valid), 64'd0);
        chk("srli_bad_pulse", 64'(err_illegal), 64'd1);
        chk("srli_bad_errcnt", 64'(err_count), 64'd1);
        send(7, 0, 4, 3, 4, 0, 0);
        chk("wrap_addr", 64'(out_addr), 64'd0);
        send(1, 1, 4, 3, 0, 'h005, 0);
        chk("subi_emit", 64'(emit_count), 64'd5);
        chk("subi_errcnt", 64'(err_count), 64'd2);

        // Backpressure: two words fill the queue, the third waits for a drain.
        out_ready = 1'b0;
        send(2, 0, 8, 9, 10, 0, 0);
        send(3, 0, 11, 12, 13, 0, 0);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4, 1, 14, 15, 0, 'h123, 0);
        repeat (4) @(posedge clk);
        #1;

        // Counter saturation at 2**CW-1.
        for (int i = 0; i < 12; i++) send(i % 8 == 1 ? 0 : i % 8, 0, i, i + 1, i + 2, 0, 0);
        chk("emit_sat", 64'(emit_count), 64'd15);
        for (int i = 0; i < 14; i++) send(1, 1, i, i, 0, i, 0);
        chk("err_sat", 64'(err_count), 64'd15);
        repeat (3) @(posedge clk);
        #1;

        // Synchronous clear with two words queued.
        out_ready = 1'b0;
        send(0, 0, 1, 1, 1, 0, 0);
        send(0, 0, 2, 2, 2, 0, 0);
        clear = 1'b1;
        @(negedge clk);
        chk("clear_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        model_reset();
        #1;
        clear = 1'b0;
        chk("clear_out_valid", 64'(out_valid), 64'd0);
        chk("clear_counts", 64'({emit_count, err_count}), 64'd0);
        out_ready = 1'b1;
        send(0, 0, 7, 7, 7, 0, 0);
        chk("clear_base_addr", 64'(out_addr), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset mid-transfer with two words queued.
        out_ready = 1'b0;
        send(4, 0, 3, 3, 3, 0, 0);
        send(4, 0, 4, 4, 4, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_out_addr", 64'(out_addr), 64'd0);
        chk("arst_emit", 64'(emit_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 300; n++) begin
            op     = int'($urandom_range(0, 7));
            is_imm = ($urandom_range(0, 1) == 1);
            if ((op == 5 || op == 6) && $urandom_range(0, 3) != 0) imm = int'($urandom_range(0, 31));
            else imm = int'($urandom_range(0, 4095));
            out_ready = ($urandom_range(0, 3) != 0);
            send(op, is_imm, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), imm, 1);
        end
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("final_drain", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
